// File: rtl/alu_share_pkg.sv
// Shared definitions for the time-shared ALU controller: default operand
// width, opcode encodings and the controller FSM states.
package alu_share_pkg;

    localparam int unsigned ALU_WIDTH = 16;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd6;
    localparam logic [2:0] OP_SLT = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_share_ctrl_alu.sv
// alu_core: combinational WIDTH-bit ALU (AND/OR/ADD/SUB/SLT).
// Optional feature macro: ALU_SHARE_OVF_EN adds the signed-overflow output.
// Ports:
//   a, b  : operands (two's complement)
//   op    : opcode (see alu_share_pkg)
//   z     : result (0 for unsupported opcodes)
//   zero  : result is zero, supported opcodes only
//   err   : unsupported opcode
//   ovf   : signed overflow for ADD/SUB (ALU_SHARE_OVF_EN only)
module alu_core
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] z,
    output logic             zero,
    output logic             err
`ifdef ALU_SHARE_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_lt;

    assign w_sum  = a + b;
    assign w_diff = a - b;
    assign w_lt   = $signed(a) < $signed(b);

    // Result select; unsupported codes return zero with err set
    always_comb begin
        z   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  z = a & b;
            OP_OR:   z = a | b;
            OP_ADD:  z = w_sum;
            OP_SUB:  z = w_diff;
            OP_SLT:  z = {{(WIDTH-1){1'b0}}, w_lt};
            default: err = 1'b1;
        endcase
    end

    assign zero = !err && (z == '0);

`ifdef ALU_SHARE_OVF_EN
    // Overflow from sign bits: ADD same-sign inputs, SUB opposite-sign inputs
    always_comb begin
        ovf = 1'b0;
        case (op)
            OP_ADD:  ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
            OP_SUB:  ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
            default: ovf = 1'b0;
        endcase
    end
`endif

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: time-shares one alu_core between NREQ requesters.
// Round-robin arbitration in IDLE, operands latched on accept, ALU evaluated
// in EXEC, registered result pulsed to the owner in RESP (1 op / 3 cycles).
// Optional feature macro: ALU_SHARE_OVF_EN adds the rsp_ovf output.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   req_valid/req_ready : per-requester handshake (ready is combinational)
//   req_a/req_b/req_op  : packed per-requester operands and opcode
//   rsp_valid           : one-cycle result pulse to the owning requester
//   rsp_z/zero/err/ovf  : shared registered result bus and flags
module alu_share_ctrl
    import alu_share_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH,
    parameter int unsigned NREQ  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ*3-1:0]     req_op,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_z,
    output logic                  rsp_zero,
    output logic                  rsp_err
`ifdef ALU_SHARE_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_last;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;

    logic [NREQ-1:0]  r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_z;
    logic             r_rsp_zero;
    logic             r_rsp_err;

    logic             w_any;
    logic [IDW-1:0]   w_win;
    logic [WIDTH-1:0] w_z;
    logic             w_zero;
    logic             w_err;

`ifdef ALU_SHARE_OVF_EN
    logic             w_ovf;
    logic             r_rsp_ovf;
`endif

    // Round-robin pick: scan from last_grant+1; the loop runs from the
    // lowest priority upward so the closest valid requester writes last.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = int'(NREQ); k >= 1; k--) begin
            if (req_valid[(int'(r_last) + k) % int'(NREQ)]) begin
                w_any = 1'b1;
                w_win = IDW'((int'(r_last) + k) % int'(NREQ));
            end
        end
    end

    // Next state and combinational grant
    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    req_ready[w_win] = 1'b1;
                    w_state_nxt      = S_EXEC;
                end
            end
            S_EXEC:  w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a    (r_a),
        .b    (r_b),
        .op   (r_op),
        .z    (w_z),
        .zero (w_zero),
        .err  (w_err)
`ifdef ALU_SHARE_OVF_EN
        ,
        .ovf  (w_ovf)
`endif
    );

    // State, request capture and registered response; reset aborts any op
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last      <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_rsp_valid <= '0;
            r_rsp_z     <= '0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
`ifdef ALU_SHARE_OVF_EN
            r_rsp_ovf   <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= '0;
            if (r_state == S_IDLE && w_any) begin
                r_id   <= w_win;
                r_last <= w_win;
                r_a    <= req_a[int'(w_win)*int'(WIDTH) +: WIDTH];
                r_b    <= req_b[int'(w_win)*int'(WIDTH) +: WIDTH];
                r_op   <= req_op[int'(w_win)*3 +: 3];
            end
            if (r_state == S_EXEC) begin
                r_rsp_valid[r_id] <= 1'b1;
                r_rsp_z           <= w_z;
                r_rsp_zero        <= w_zero;
                r_rsp_err         <= w_err;
`ifdef ALU_SHARE_OVF_EN
                r_rsp_ovf         <= w_ovf;
`endif
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_z     = r_rsp_z;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;
`ifdef ALU_SHARE_OVF_EN
    assign rsp_ovf   = r_rsp_ovf;
`endif

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: fixed vectors, hand sequences for contention and
// reset mid-operation, then random traffic against a cycle-level reference.
module tb_alu_share_ctrl;

    localparam int NREQ = 2;
    localparam int W    = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ*3-1:0] req_op;
    logic [NREQ-1:0]   rsp_valid;
    logic [W-1:0]      rsp_z;
    logic              rsp_zero;
    logic              rsp_err;
`ifdef ALU_SHARE_OVF_EN
    logic              rsp_ovf;
`endif

    alu_share_ctrl #(.WIDTH(W), .NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_z     (rsp_z),
        .rsp_zero  (rsp_zero),
        .rsp_err   (rsp_err)
`ifdef ALU_SHARE_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z;
        logic         zero;
        logic         err;
        logic         ovf;
    } res_t;

    typedef struct {
        int   due;
        int   id;
        res_t r;
    } pend_t;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2:0]   op;
        logic [W-1:0] ez;
        logic         ezero;
        logic         eerr;
        logic         eovf;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from integer arithmetic on sign-extended operands
    function automatic res_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [2:0] op);
        res_t r;
        int   sa;
        int   sb;
        int   s;
        sa = int'($signed(a));
        sb = int'($signed(b));
        r  = '{z: '0, zero: 1'b0, err: 1'b0, ovf: 1'b0};
        case (op)
            3'd0: r.z = a & b;
            3'd1: r.z = a | b;
            3'd2: begin s = sa + sb; r.z = W'(s); r.ovf = (s > 32767) || (s < -32768); end
            3'd6: begin s = sa - sb; r.z = W'(s); r.ovf = (s > 32767) || (s < -32768); end
            3'd7: r.z = (sa < sb) ? W'(1) : W'(0);
            default: r.err = 1'b1;
        endcase
        if (!r.err) r.zero = (r.z == '0);
        return r;
    endfunction

    // ---------------- cycle-level reference monitor ----------------
    bit    mon_en = 1'b0;
    int    m_busy;
    int    m_last;
    int    m_cyc;
    bit    m_post_reset;
    pend_t pend[$];

    always @(negedge clk) begin
        if (mon_en) begin
            logic [NREQ-1:0] exp_rdy;
            logic [NREQ-1:0] exp_rv;
            bit              found;
            int              win;
            pend_t           e;
            exp_rdy = '0;
            exp_rv  = '0;
            found   = 1'b0;
            win     = 0;
            if (m_busy == 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (!found && req_valid[(m_last + k) % NREQ]) begin
                        found = 1'b1;
                        win   = (m_last + k) % NREQ;
                    end
                end
                if (found) exp_rdy[win] = 1'b1;
            end
            chk("mon_ready", 32'(req_ready), 32'(exp_rdy));
            if (pend.size() > 0 && pend[0].due == m_cyc) begin
                e = pend.pop_front();
                exp_rv[e.id] = 1'b1;
                chk("mon_z", 32'(rsp_z), 32'(e.r.z));
                chk("mon_zero", 32'(rsp_zero), 32'(e.r.zero));
                chk("mon_err", 32'(rsp_err), 32'(e.r.err));
`ifdef ALU_SHARE_OVF_EN
                chk("mon_ovf", 32'(rsp_ovf), 32'(e.r.ovf));
`endif
            end else if (m_post_reset) begin
                chk("rst_z", 32'(rsp_z), 32'd0);
                chk("rst_flags", 32'({rsp_zero, rsp_err}), 32'd0);
`ifdef ALU_SHARE_OVF_EN
                chk("rst_ovf", 32'(rsp_ovf), 32'd0);
`endif
            end
            chk("mon_rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            m_post_reset = 1'b0;
            if (!rst_n) begin
                m_busy       = 0;
                m_last       = NREQ - 1;
                m_post_reset = 1'b1;
                pend.delete();
            end else if (found) begin
                pend.push_back('{due: m_cyc + 2, id: win,
                                 r: ref_alu(req_a[win*W +: W], req_b[win*W +: W],
                                            req_op[win*3 +: 3])});
                m_last = win;
                m_busy = 2;
            end else if (m_busy > 0) begin
                m_busy--;
            end
            m_cyc++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2:0] op);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
        req_op[id*3 +: 3] = op;
        req_valid[id] = 1'b1;
    endtask

    task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2:0] op, output res_t got);
        int cnt;
        bit ok;
        got = '{z: '0, zero: 1'b0, err: 1'b0, ovf: 1'b0};
        @(posedge clk); #1;
        set_req(id, a, b, op);
        ok  = 1'b0;
        cnt = 0;
        while (!ok && cnt < 20) begin
            @(negedge clk);
            ok = req_ready[id];
            cnt++;
        end
        chk("grant_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        if (ok) begin
            @(negedge clk);
            chk("lat_t1", 32'(rsp_valid), 32'd0);
            @(negedge clk);
            chk("lat_t2", 32'(rsp_valid), 32'(1 << id));
            got.z    = rsp_z;
            got.zero = rsp_zero;
            got.err  = rsp_err;
`ifdef ALU_SHARE_OVF_EN
            got.ovf  = rsp_ovf;
`endif
        end
    endtask

    function automatic logic [W-1:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return W'(0);
            1: return W'(1);
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'hFFFF;
            default: return W'($urandom);
        endcase
    endfunction

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t            got;
        logic [NREQ-1:0] rdy;
        int              cnt;
        bit              ok;

        tbl[0]  = '{0, 16'd5,    16'd5,    3'd6, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{1, 16'hFFFD, 16'd2,    3'd7, 16'h0001, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{0, 16'd2,    16'hFFFD, 3'd7, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1, 16'd7,    16'd9,    3'd4, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{0, 16'hF0F0, 16'h0FF0, 3'd0, 16'h00F0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1, 16'h00F0, 16'h0F00, 3'd1, 16'h0FF0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{0, 16'h7FFF, 16'd1,    3'd2, 16'h8000, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1, 16'h8000, 16'd1,    3'd6, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{0, 16'd1,    16'd1,    3'd2, 16'h0002, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1, 16'hFFFF, 16'd1,    3'd2, 16'h0000, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{0, 16'h1234, 16'h4321, 3'd3, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1, 16'h8000, 16'h7FFF, 3'd7, 16'h0001, 1'b0, 1'b0, 1'b0};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;

        // Reset; the monitor starts from the reset state
        @(posedge clk); #1;
        m_busy       = 0;
        m_last       = NREQ - 1;
        m_cyc        = 0;
        m_post_reset = 1'b1;
        mon_en       = 1'b1;
        @(posedge clk); #1;
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_z", 32'(rsp_z), 32'd0);
        rst_n = 1'b1;

        // Contention from reset: both valid, grants alternate starting at req0
        set_req(0, 16'd100, 16'hFFD8, 3'd2);
        set_req(1, 16'hF0F0, 16'h0FF0, 3'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("cont_ready", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
            chk("cont_exec_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            chk("cont_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
            chk("cont_z", 32'(rsp_z), (k % 2 == 0) ? 32'h003C : 32'h00F0);
            chk("cont_resp_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (3) @(posedge clk);

        // Table of single operations
        foreach (tbl[i]) begin
            run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, got);
            chk($sformatf("tbl%0d_z", i), 32'(got.z), 32'(tbl[i].ez));
            chk($sformatf("tbl%0d_zero", i), 32'(got.zero), 32'(tbl[i].ezero));
            chk($sformatf("tbl%0d_err", i), 32'(got.err), 32'(tbl[i].eerr));
`ifdef ALU_SHARE_OVF_EN
            chk($sformatf("tbl%0d_ovf", i), 32'(got.ovf), 32'(tbl[i].eovf));
`endif
        end

        // Reset during EXEC: no response, outputs zero, req0 first again
        run_op(0, 16'd1, 16'd2, 3'd2, got);
        @(posedge clk); #1;
        set_req(0, 16'd3, 16'd4, 3'd2);
        ok  = 1'b0;
        cnt = 0;
        while (!ok && cnt < 20) begin
            @(negedge clk);
            ok = req_ready[0];
            cnt++;
        end
        chk("rst_grant_wait", 32'(ok), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        chk("rst_exec_rsp", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_req(0, 16'd8, 16'd8, 3'd6);
        set_req(1, 16'd8, 16'd9, 3'd6);
        @(negedge clk);
        chk("rst_abort_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_abort_z", 32'(rsp_z), 32'd0);
        chk("rst_abort_flags", 32'({rsp_zero, rsp_err}), 32'd0);
        chk("rst_first_grant", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_after_rsp", 32'(rsp_valid), 32'd1);
        chk("rst_after_zero", 32'(rsp_zero), 32'd1);
        repeat (2) @(posedge clk);

        // Random traffic with holds, withdrawals and occasional resets
        rdy = '0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            rdy = req_ready;
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 199) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (req_valid[i] && !rdy[i]) begin
                    if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
                end else begin
                    req_a[i*W +: W]   = rnd_operand();
                    req_b[i*W +: W]   = rnd_operand();
                    req_op[i*3 +: 3]  = 3'($urandom_range(0, 7));
                    req_valid[i]      = ($urandom_range(0, 2) != 0);
                end
            end
        end
        @(posedge clk); #1;
        rst_n     = 1'b1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        chk("drain_pending", 32'(pend.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
